// File: rtl/time_keeper_set_if.sv
// Bus between the time keeper and its user side: switches/buttons in, BCD time,
// alarm, seconds, strobes and mode out.
interface time_keeper_set_if;
  logic        set_time;
  logic        set_alarm;
  logic        push_h;
  logic        push_min;
  logic [15:0] current;
  logic [15:0] alarm;
  logic [5:0]  seconds;
  logic        sec_pulse;
  logic        min_pulse;
  logic [1:0]  mode;

  modport master (
    output set_time, set_alarm, push_h, push_min,
    input  current, alarm, seconds, sec_pulse, min_pulse, mode
  );

  modport slave (
    input  set_time, set_alarm, push_h, push_min,
    output current, alarm, seconds, sec_pulse, min_pulse, mode
  );
endinterface

// File: rtl/time_keeper_set.sv
// Wall-clock HH:MM:SS keeper with alarm register and two-button editing.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on the edit buttons.
module time_keeper_set #(
`ifdef AUTO_REPEAT_EN
  parameter int REPEAT_TICKS = 25000000,
`endif
  parameter int TICK_DIV = 100000000
) (
  input logic              clk,
  input logic              resetn,
  time_keeper_set_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10
  } mode_t;

  mode_t          mode_r;
  mode_t          mode_next_s;
  logic [PW-1:0]  presc_r;
  logic [5:0]     seconds_r;
  logic [7:0]     hours_r;
  logic [7:0]     minutes_r;
  logic [7:0]     alarm_hours_r;
  logic [7:0]     alarm_minutes_r;
  logic           sec_pulse_r;
  logic           min_pulse_r;
  logic           push_h_q_r;
  logic           push_min_q_r;
  logic           inc_h_s;
  logic           inc_min_s;

  // Two-digit BCD increment that wraps to 00 after 'last'; digits stay 0..9.
  function automatic logic [7:0] bcd_wrap_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Mode follows the switches every cycle; set_time wins over set_alarm.
  always_comb begin
    mode_next_s = MODE_RUN;
    if (bus.set_time) begin
      mode_next_s = MODE_SET_TIME;
    end else if (bus.set_alarm) begin
      mode_next_s = MODE_SET_ALARM;
    end else begin
      mode_next_s = MODE_RUN;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  logic [RW-1:0] hold_h_r;
  logic [RW-1:0] hold_min_r;
  logic          edit_mode_s;
  logic          mode_change_s;
  logic          held_h_s;
  logic          held_min_s;
  logic          rep_h_s;
  logic          rep_min_s;

  assign edit_mode_s   = (mode_next_s != MODE_RUN);
  assign mode_change_s = (mode_next_s != mode_r);
  assign held_h_s      = edit_mode_s & ~mode_change_s & bus.push_h & push_h_q_r;
  assign held_min_s    = edit_mode_s & ~mode_change_s & bus.push_min & push_min_q_r;
  assign rep_h_s       = held_h_s & (hold_h_r == RW'(REPEAT_TICKS - 1));
  assign rep_min_s     = held_min_s & (hold_min_r == RW'(REPEAT_TICKS - 1));

  // Per-button hold counters; any break in the hold restarts the count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_h_r   <= {RW{1'b0}};
      hold_min_r <= {RW{1'b0}};
    end else begin
      if (!held_h_s || rep_h_s) begin
        hold_h_r <= {RW{1'b0}};
      end else begin
        hold_h_r <= hold_h_r + RW'(1);
      end
      if (!held_min_s || rep_min_s) begin
        hold_min_r <= {RW{1'b0}};
      end else begin
        hold_min_r <= hold_min_r + RW'(1);
      end
    end
  end
`endif

  // Edit strobes: a fresh press, plus auto-repeat steps when enabled.
  always_comb begin
    inc_h_s   = bus.push_h & ~push_h_q_r;
    inc_min_s = bus.push_min & ~push_min_q_r;
`ifdef AUTO_REPEAT_EN
    inc_h_s   = inc_h_s | rep_h_s;
    inc_min_s = inc_min_s | rep_min_s;
`else
    inc_h_s   = inc_h_s & 1'b1;
    inc_min_s = inc_min_s & 1'b1;
`endif
  end

  // Mode register and button edge history, kept up to date in every mode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_r       <= MODE_RUN;
      push_h_q_r   <= 1'b0;
      push_min_q_r <= 1'b0;
    end else begin
      mode_r       <= mode_next_s;
      push_h_q_r   <= bus.push_h;
      push_min_q_r <= bus.push_min;
    end
  end

  // Timekeeping, time edits and alarm edits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_r         <= {PW{1'b0}};
      seconds_r       <= 6'd0;
      hours_r         <= 8'h00;
      minutes_r       <= 8'h00;
      alarm_hours_r   <= 8'h07;
      alarm_minutes_r <= 8'h00;
      sec_pulse_r     <= 1'b0;
      min_pulse_r     <= 1'b0;
    end else begin
      sec_pulse_r <= 1'b0;
      min_pulse_r <= 1'b0;
      if (mode_next_s == MODE_SET_TIME) begin
        // Clock is frozen at :00 while being set; fields edit without carry.
        presc_r   <= {PW{1'b0}};
        seconds_r <= 6'd0;
        if (inc_h_s) begin
          hours_r <= bcd_wrap_inc(hours_r, 8'h23);
        end
        if (inc_min_s) begin
          minutes_r <= bcd_wrap_inc(minutes_r, 8'h59);
        end
      end else begin
        if (presc_r == PW'(TICK_DIV - 1)) begin
          presc_r     <= {PW{1'b0}};
          sec_pulse_r <= 1'b1;
          if (seconds_r == 6'd59) begin
            seconds_r   <= 6'd0;
            min_pulse_r <= 1'b1;
            minutes_r   <= bcd_wrap_inc(minutes_r, 8'h59);
            if (minutes_r == 8'h59) begin
              hours_r <= bcd_wrap_inc(hours_r, 8'h23);
            end
          end else begin
            seconds_r <= seconds_r + 6'd1;
          end
        end else begin
          presc_r <= presc_r + PW'(1);
        end
        if (mode_next_s == MODE_SET_ALARM) begin
          if (inc_h_s) begin
            alarm_hours_r <= bcd_wrap_inc(alarm_hours_r, 8'h23);
          end
          if (inc_min_s) begin
            alarm_minutes_r <= bcd_wrap_inc(alarm_minutes_r, 8'h59);
          end
        end
      end
    end
  end

  assign bus.current   = {hours_r, minutes_r};
  assign bus.alarm     = {alarm_hours_r, alarm_minutes_r};
  assign bus.seconds   = seconds_r;
  assign bus.sec_pulse = sec_pulse_r;
  assign bus.min_pulse = min_pulse_r;
  assign bus.mode      = mode_r;

endmodule

// File: doc/time_keeper_set.md
Name: time_keeper_set

Overview:
- Upstream stage of the alarm checker.
- Keeps wall-clock time in BCD HH:MM (plus a seconds counter) and holds the alarm time.
- Lets the user edit either value with two push buttons.
- Drives the checker's current[15:0] and alarm[15:0] buses directly.

Parameters:
TICK_DIV, 100000000, clk cycles per second (≥2)
REPEAT_TICKS, 25000000, hold cycles per auto-repeat step (used only with AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock
resetn  input  1  reset; synchronous, active-low
set_time  input  1  level switch: enter time-set mode
set_alarm  input  1  level switch: enter alarm-set mode
push_h  input  1  hour-increment button (level, pre-synchronised)
push_min  input  1  minute-increment button (level, pre-synchronised)
current  output  16  {Ht,Ho,Mt,Mo} BCD current time
alarm  output  16  {Ht,Ho,Mt,Mo} BCD alarm time
seconds  output  6  binary seconds 0..59
sec_pulse  output  1  one-cycle strobe when seconds advances
min_pulse  output  1  one-cycle strobe when running minute advances
mode  output  2  00 RUN, 01 SET_TIME, 10 SET_ALARM

Behaviour:
- Reset (resetn low at clk edge) values:
  - current=16'h0000, alarm=16'h0700, seconds=0, prescaler=0.
  - sec_pulse=0, min_pulse=0, mode=RUN.
  - Button history registers=0.
  - Reset mid-edit discards the edit and returns to these values.
- All outputs are registered.
- Mode FSM, evaluated every cycle:
  - set_time=1 → SET_TIME.
  - Else set_alarm=1 → SET_ALARM.
  - Else RUN.
  - set_time has priority if both are high.
- Button edge: press = button & ~button_q, where button_q is the previous sample.
  - A press sampled at edge N updates the field at edge N; the new value is visible from cycle N+1.
  - Holding a button gives exactly one increment.
- Prescaler runs 0..TICK_DIV-1 in RUN and SET_ALARM.
  - At TICK_DIV-1 it returns to 0, seconds increments, and sec_pulse=1 for that cycle.
  - The first sec_pulse occurs TICK_DIV cycles after reset release.
- Seconds 59→0 advances minutes and pulses min_pulse in the same cycle.
- Minutes BCD wraps 59→00 and carries into hours.
- Hours BCD wraps 23→00; full rollover is 23:59:59 → 00:00:00.
- BCD digits never take values A–F. Ones digit 9→0 carries into tens.
- SET_TIME:
  - Prescaler and seconds are held at 0; both are cleared on entry.
  - No sec_pulse or min_pulse.
  - push_h increments hours 00..23 with wrap and no carry.
  - push_min increments minutes 00..59 with wrap and no carry into hours.
  - Leaving SET_TIME resumes counting from prescaler 0, seconds 0.
- SET_ALARM:
  - Time keeps running normally.
  - Buttons edit alarm with the same wrap and no-carry rules.
  - current is unaffected by buttons.
- RUN: button presses are ignored, but edge history is still updated.
- Simultaneous events:
  - push_h and push_min pressed in the same cycle → both fields increment.
  - In SET_ALARM, a time tick and an alarm edit in the same cycle are both applied independently.

Optional Feature:
AUTO_REPEAT_EN:
- Defined:
  - A button held in a set mode triggers one increment on press.
  - After REPEAT_TICKS continuous held cycles, it increments again, then every further REPEAT_TICKS cycles.
  - Each button has its own hold counter. The counter clears on release, on mode change, and on reset.
- Undefined: exactly one increment per press; hold counters are absent.

Test Plan:
- TICK_DIV=4: release reset, run 4 cycles → sec_pulse in cycle 4; seconds=1, current=16'h0000.
- Preload via SET_TIME to 23:59; return to RUN; run 60·TICK_DIV cycles → current=16'h0000, seconds=0, min_pulse high one cycle.
- SET_TIME from reset: 13 push_h presses, 9 push_min presses → current=16'h1309; hold push_h 20 cycles (macro off) → exactly one increment.
- SET_ALARM: 24 push_h presses → alarm hours wrap back to 07 (16'h0700); current continues ticking with sec_pulse every 4 cycles.
- set_time=1 and set_alarm=1 together → mode=01; pressing push_min edits current, alarm unchanged. Same-cycle push_h+push_min from 09:59 → 10:00 (each field increments independently, no carry).
- Assert resetn low mid-edit at 16'h1530 → next cycle current=16'h0000, alarm=16'h0700, mode=00. With AUTO_REPEAT_EN and REPEAT_TICKS=3, hold push_min 10 cycles in SET_TIME → minutes 00→04.
